// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: widths of the product,
// bias and pixel buses, the tap-counter width helper and the ReLU/saturate
// function that later pooling stages reuse.
package conv_pkg;

    localparam int PROD_W      = 16;
    localparam int ACC_W       = 21;
    localparam int OUT_W       = 8;
    localparam int DEF_TAPS    = 9;

    // Width of a counter that indexes 0..taps-1 (at least one bit).
    function automatic int tap_cnt_w(input int taps);
        return (taps < 2) ? 1 : $clog2(taps);
    endfunction

    localparam int TAP_CNT_W = tap_cnt_w(DEF_TAPS);

    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << OUT_W) - 1);

    // Negative values become 0, values above the pixel range clamp to all-ones.
    function automatic logic [OUT_W-1:0] sat_relu(input logic signed [ACC_W:0] v);
        if (v[ACC_W]) begin
            return '0;
        end
        if (v > PIX_MAX) begin
            return '1;
        end
        return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/conv_accum_if.sv
// Product-in / pixel-out stream bundle between the multiplier, the
// accumulator and the downstream consumer.
interface conv_accum_if;
    import conv_pkg::*;

    logic [PROD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/conv_postproc.sv
// Combinational post-processing of a finished window sum: arithmetic right
// shift (rounds toward -inf), then ReLU and clamp into the pixel range.
module conv_postproc
    import conv_pkg::*;
#(
    parameter int SHIFT = 6
) (
    input  logic signed [ACC_W:0] i_sum,
    output logic [OUT_W-1:0]      o_pix
);
    logic signed [ACC_W:0] w_shr;

    assign w_shr = i_sum >>> SHIFT;
    assign o_pix = sat_relu(w_shr);
endmodule

// File: rtl/conv_accum.sv
// Window accumulator: sums KERNEL_TAPS unsigned products plus a signed bias,
// post-processes the sum into one pixel and holds it behind valid/ready.
module conv_accum
    import conv_pkg::*;
#(
    parameter int KERNEL_TAPS = 9,
    parameter int SHIFT       = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic signed [ACC_W-1:0]           bias,
    conv_accum_if.slave                       bus,
    output logic [tap_cnt_w(KERNEL_TAPS)-1:0] tap_idx
);
    localparam int               TAP_W    = tap_cnt_w(KERNEL_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_TAPS - 1);
    // Largest positive sum the window can reach: all products at full scale
    // plus the most positive bias. It must fit the ACC_W+1 signed sum.
    localparam longint SUM_MAX   = longint'(KERNEL_TAPS) * ((longint'(1) << PROD_W) - 1)
                                 + (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint SUM_LIMIT = longint'(1) << ACC_W;

    if (KERNEL_TAPS < 2 || SUM_MAX >= SUM_LIMIT) begin : g_param_check
        $error("conv_accum: KERNEL_TAPS too small or window sum can overflow ACC_W+1 bits");
    end

    logic signed [ACC_W:0] r_acc_p0;
    logic [TAP_W-1:0]      r_tap_p0;
    logic [OUT_W-1:0]      r_out_p1;
    logic                  r_vld_p1;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_first;
    logic                  w_last;
    logic signed [ACC_W:0] w_base;
    logic signed [ACC_W:0] w_prod;
    logic signed [ACC_W:0] w_sum;
    logic [OUT_W-1:0]      w_pix;

    // A held result only blocks input while the consumer is not taking it.
    assign w_in_ready = !r_vld_p1 || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !clear;
    assign w_first    = (r_tap_p0 == '0);
    assign w_last     = (r_tap_p0 == LAST_TAP);

    // The first tap restarts the sum from the bias instead of the old total.
    assign w_base = w_first ? {bias[ACC_W-1], bias} : r_acc_p0;
    assign w_prod = $signed({{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_data});
    assign w_sum  = w_base + w_prod;

    conv_postproc #(
        .SHIFT (SHIFT)
    ) u_postproc (
        .i_sum (w_sum),
        .o_pix (w_pix)
    );

    // ---- stage p0: running sum and tap position ----
    // Clear drops the partial window and any beat presented alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_p0 <= '0;
            r_tap_p0 <= '0;
        end else if (clear) begin
            r_acc_p0 <= '0;
            r_tap_p0 <= '0;
        end else if (w_accept) begin
            r_acc_p0 <= w_sum;
            r_tap_p0 <= w_last ? '0 : r_tap_p0 + TAP_W'(1);
        end
    end

    // ---- stage p1: pixel output register ----
    // A completion overwrites even while the previous pixel is being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else if (w_accept && w_last) begin
            r_out_p1 <= w_pix;
            r_vld_p1 <= 1'b1;
        end else if (bus.out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_p1;
    assign bus.out_valid = r_vld_p1;
    assign tap_idx       = r_tap_p0;
endmodule

// File: tb/tb_conv_accum.sv
// Bench for conv_accum: directed windows plus a randomized-gap run, checked
// every cycle against a window-level model of the accumulator.
module tb_conv_accum;
    localparam int TAPS = 9;
    localparam int DIV  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic signed [20:0] bias;
    logic [3:0]        tap_idx;

    conv_accum_if bus ();

    conv_accum #(
        .KERNEL_TAPS (TAPS),
        .SHIFT       (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .bias    (bias),
        .bus     (bus),
        .tap_idx (tap_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level reference model ----------------
    int     win[$];
    longint win_bias;
    bit     m_vld = 0;
    int     m_pix = 0;
    int     m_last_pix = -1;
    int     delivered[$];
    int     wraps = 0;
    bit     started = 0;
    int     vld_cycles = 0;
    bit     rand_on = 0;

    function automatic int pix_of(input longint s);
        longint t;
        if (s >= 0) t = s / DIV;
        else        t = -((-s + DIV - 1) / DIV);
        if (t < 0)   return 0;
        if (t > 255) return 255;
        return int'(t);
    endfunction

    always @(posedge clk) begin
        bit     acc;
        bit     done;
        longint s;
        done = 0;
        if (rst) begin
            win.delete();
            m_vld = 0;
            m_pix = 0;
        end else begin
            acc = bus.in_valid && (!m_vld || bus.out_ready) && !clear;
            if (m_vld && bus.out_ready) delivered.push_back(m_pix);
            if (clear) begin
                win.delete();
            end else if (acc) begin
                if (win.size() == 0) win_bias = longint'(bias);
                win.push_back(int'(bus.in_data));
                if (win.size() == TAPS) begin
                    s = win_bias;
                    foreach (win[k]) s += win[k];
                    m_pix      = pix_of(s);
                    m_last_pix = m_pix;
                    done       = 1;
                    wraps++;
                    win.delete();
                end
            end
            if (done) m_vld = 1;
            else if (m_vld && bus.out_ready) m_vld = 0;
        end
        started = 1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",  32'(bus.in_ready),  int'(!m_vld || bus.out_ready));
            chk("out_valid", 32'(bus.out_valid), int'(m_vld));
            chk("out_data",  32'(bus.out_data),  m_pix);
            chk("tap_idx",   32'(tap_idx),       win.size());
            if (bus.out_valid === 1'b1) vld_cycles++;
        end
    end

    // Randomized consumer back-pressure for the long run.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_on) bus.out_ready = ($urandom_range(0, 99) < 75);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic feed(input int vals[$], input int b, input int gap);
        int  budget;
        int  v;
        bit  will;
        for (int k = 0; k < vals.size(); k++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            v            = vals[k];
            bus.in_valid = 1'b1;
            bus.in_data  = v[15:0];
            bias         = b[20:0];
            budget       = 0;
            forever begin
                @(negedge clk);
                will = (!m_vld || bus.out_ready) && !clear;
                @(posedge clk);
                #1;
                budget++;
                if (will) break;
                if (budget > 500) begin
                    chk("feed_timeout", 32'(budget), 0);
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic fill(output int q[$], input int n, input int val);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(val);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int n0;
        int w0;
        int rv[$];
        int rb;
        rst           = 1'b1;
        clear         = 1'b0;
        bias          = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_tap",    32'(tap_idx),       0);
        chk("rst_vld",    32'(bus.out_valid), 0);
        chk("rst_data",   32'(bus.out_data),  0);
        chk("rst_ready",  32'(bus.in_ready),  1);
        @(posedge clk);
        #1;

        // 9 x 1000, bias 0 -> 140, valid exactly one cycle
        vld_cycles = 0;
        fill(q, 9, 1000);
        feed(q, 0, 0);
        idle(4);
        chk("w1000_pix",  32'(m_last_pix), 140);
        chk("w1000_vldc", 32'(vld_cycles), 1);
        chk("w1000_dlv",  32'(delivered[$]), 140);

        // 9 x 65025 -> saturates at 255
        fill(q, 9, 65025);
        feed(q, 0, 0);
        idle(3);
        chk("wsat_pix", 32'(m_last_pix), 255);

        // negative sum -> ReLU to 0, then bias 64 with zeros -> 1
        fill(q, 9, 1000);
        feed(q, -10000, 0);
        idle(3);
        chk("wneg_pix", 32'(m_last_pix), 0);
        fill(q, 9, 0);
        feed(q, 64, 0);
        idle(3);
        chk("wbias_pix", 32'(m_last_pix), 1);

        // back-pressure: first result held, second window stalls then follows
        n0 = delivered.size();
        fill(q, 9, 640);
        feed(q, 0, 0);
        bus.out_ready = 1'b0;
        fork
            begin
                int q2[$];
                fill(q2, 9, 128);
                feed(q2, 0, 0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_data",  32'(bus.out_data),  90);
                    chk("stall_vld",   32'(bus.out_valid), 1);
                    chk("stall_ready", 32'(bus.in_ready),  0);
                    chk("stall_tap",   32'(tap_idx),       0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(4);
        chk("stall_count", 32'(delivered.size() - n0), 2);
        chk("stall_first", 32'(delivered[n0]),         90);
        chk("stall_second", 32'(delivered[n0 + 1]),    18);

        // clear aborts a partial window and drops the coincident beat
        fill(q, 4, 500);
        feed(q, 0, 0);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd999;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clear_tap", 32'(tap_idx), 0);
        fill(q, 9, 64);
        feed(q, 0, 0);
        idle(3);
        chk("clear_pix", 32'(m_last_pix), 9);

        // reset mid-window, then a full window computes from scratch
        fill(q, 5, 1000);
        feed(q, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tap", 32'(tap_idx),       0);
        chk("midrst_vld", 32'(bus.out_valid), 0);
        fill(q, 9, 1000);
        feed(q, 0, 0);
        idle(3);
        chk("midrst_pix", 32'(m_last_pix), 140);

        // 100 windows with ~50% input gaps and random back-pressure
        n0 = delivered.size();
        w0 = wraps;
        rand_on = 1'b1;
        for (int w = 0; w < 100; w++) begin
            rv.delete();
            for (int k = 0; k < TAPS; k++) rv.push_back($urandom_range(0, 3000));
            rb = int'($urandom_range(0, 40000)) - 20000;
            feed(rv, rb, 50);
        end
        rand_on = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idle(4);
        chk("rand_wraps", 32'(wraps - w0), 100);
        chk("rand_dlv",   32'(delivered.size() - n0), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
